// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART access controller.
// State encoding, data width, guard length and status bit positions.
package uart_ctrl_pkg;

    localparam int DATA_W       = 8;
    localparam int GUARD_CYCLES = 15;

    localparam int ST_TX_FULL  = 3;
    localparam int ST_TX_EMPTY = 2;
    localparam int ST_RX_VALID = 1;
    localparam int ST_BUSY     = 0;

    typedef enum logic [2:0] {
        IDLE,
        WR_STROBE,
        WR_WAIT,
        RD_STROBE,
        RD_HOLD
    } state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous TX FIFO; depth must be a power of two.
// Pushes into a full FIFO are dropped even if a pop happens that cycle.
module uart_tx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [AW:0]       cnt_q;
    logic              do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rptr_q];

    // Storage array; contents need no reset, pointers define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy; reset discards everything queued.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_q + {{AW{1'b0}}, do_push}
                           - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/uart_access_ctrl.sv
// Round-robin TX arbitration, TX FIFO and registered UART strobes.
// Reads take priority over writes; RX byte held until consumed.
module uart_access_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int TX_DEPTH      = 4,
    parameter int STROBE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    input  logic              rx_ready,
    input  logic              tbre,
    input  logic              tsre,
    input  logic              data_ready,
    output logic [DATA_W-1:0] uart_din,
    input  logic [DATA_W-1:0] uart_dout,
    output logic              wrn,
    output logic              rdn,
    output logic [3:0]        status
);

    localparam logic [2:0] STB_LAST   = 3'(STROBE_CYCLES - 1);
    localparam logic [3:0] GUARD_LAST = 4'(GUARD_CYCLES - 1);

    state_e            state_q, state_d;
    logic [2:0]        stb_q, stb_d;
    logic [3:0]        guard_q, guard_d;
    logic              last_q;
    logic              wrn_q, wrn_d, rdn_q, rdn_d;
    logic              rxv_q, rxv_d;
    logic [DATA_W-1:0] din_q, din_d, rxd_q, rxd_d;
    logic              tx_full, tx_empty;
    logic              grant0, grant1, push, pop;
    logic [DATA_W-1:0] push_data, fifo_head;

    // last_q = 1 means requester 1 was served last, so 0 wins a tie.
    assign grant0     = req0_valid & (~req1_valid | last_q);
    assign grant1     = req1_valid & (~req0_valid | ~last_q);
    assign req0_ready = grant0 & ~tx_full & rst;
    assign req1_ready = grant1 & ~tx_full & rst;
    assign push       = req0_ready | req1_ready;
    assign push_data  = req0_ready ? req0_data : req1_data;

    assign wrn      = wrn_q;
    assign rdn      = rdn_q;
    assign uart_din = din_q;
    assign rx_valid = rxv_q;
    assign rx_data  = rxd_q;

    uart_tx_fifo #(
        .DATA_W(DATA_W),
        .DEPTH (TX_DEPTH)
    ) u_fifo (
        .clk_i  (clk),
        .rst_ni (rst),
        .push_i (push),
        .wdata_i(push_data),
        .pop_i  (pop),
        .rdata_o(fifo_head),
        .full_o (tx_full),
        .empty_o(tx_empty)
    );

    // Status word assembled from FIFO flags, RX holding and FSM.
    always_comb begin
        status              = '0;
        status[ST_TX_FULL]  = tx_full;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_RX_VALID] = rxv_q;
        status[ST_BUSY]     = (state_q != IDLE);
    end

    // Next state, strobe/guard counters and data captures.
    always_comb begin
        state_d = state_q;
        stb_d   = stb_q;
        guard_d = guard_q;
        din_d   = din_q;
        rxd_d   = rxd_q;
        rxv_d   = rxv_q & ~rx_ready;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (data_ready && !rxv_q) begin
                    state_d = RD_STROBE;
                end else if (!tx_empty && tbre && tsre) begin
                    state_d = WR_STROBE;
                    din_d   = fifo_head;
                end
            end
            WR_STROBE: begin
                if (stb_q == STB_LAST) begin
                    stb_d   = '0;
                    pop     = 1'b1;
                    state_d = WR_WAIT;
                end else begin
                    stb_d = stb_q + 3'd1;
                end
            end
            WR_WAIT: begin
                if (!tbre || guard_q == GUARD_LAST) begin
                    guard_d = '0;
                    state_d = IDLE;
                end else begin
                    guard_d = guard_q + 4'd1;
                end
            end
            RD_STROBE: begin
                if (stb_q == STB_LAST) begin
                    stb_d   = '0;
                    rxd_d   = uart_dout;
                    rxv_d   = 1'b1;
                    state_d = RD_HOLD;
                end else begin
                    stb_d = stb_q + 3'd1;
                end
            end
            RD_HOLD: begin
                if (!data_ready || guard_q == GUARD_LAST) begin
                    guard_d = '0;
                    state_d = IDLE;
                end else begin
                    guard_d = guard_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        wrn_d = (state_d != WR_STROBE);
        rdn_d = (state_d != RD_STROBE);
    end

    // State and registered outputs; reset releases strobes at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            stb_q   <= '0;
            guard_q <= '0;
            last_q  <= 1'b1;
            wrn_q   <= 1'b1;
            rdn_q   <= 1'b1;
            din_q   <= '0;
            rxd_q   <= '0;
            rxv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stb_q   <= stb_d;
            guard_q <= guard_d;
            wrn_q   <= wrn_d;
            rdn_q   <= rdn_d;
            din_q   <= din_d;
            rxd_q   <= rxd_d;
            rxv_q   <= rxv_d;
            if (req0_ready)      last_q <= 1'b0;
            else if (req1_ready) last_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_access_ctrl.sv
// Bench for uart_access_ctrl: directed scenarios on one instance,
// random traffic vs. a transaction-level model at widths 2, 1 and 7.
module tb_uart_access_ctrl;

    logic clk = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   done = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- directed instance (strobe width 2) ----------------
    logic       d_rst, d_r0v, d_r1v, d_r0r, d_r1r;
    logic       d_rxv, d_rxr, d_tbre, d_tsre, d_dr, d_wrn, d_rdn;
    logic [7:0] d_r0d, d_r1d, d_rxd, d_din, d_dout;
    logic [3:0] d_st;

    uart_access_ctrl #(.TX_DEPTH(4), .STROBE_CYCLES(2)) u_dut (
        .clk(clk), .rst(d_rst),
        .req0_valid(d_r0v), .req0_data(d_r0d), .req0_ready(d_r0r),
        .req1_valid(d_r1v), .req1_data(d_r1d), .req1_ready(d_r1r),
        .rx_valid(d_rxv), .rx_data(d_rxd), .rx_ready(d_rxr),
        .tbre(d_tbre), .tsre(d_tsre), .data_ready(d_dr),
        .uart_din(d_din), .uart_dout(d_dout),
        .wrn(d_wrn), .rdn(d_rdn), .status(d_st)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wwait(input bit rd, input logic lvl, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = ((rd ? d_rdn : d_wrn) == lvl);
        end
        chk(tag, 32'(ok), 1);
    endtask

    task automatic push0(input logic [7:0] b);
        step();
        d_r0v = 1'b1;
        d_r0d = b;
        step();
        d_r0v = 1'b0;
    endtask

    initial begin : directed
        logic [3:0] wexp;
        logic [1:0] rexp [5];
        int         n, lows, wl;
        bit         seen;
        d_rst = 1'b0; d_r0v = 1'b1; d_r1v = 1'b1;
        d_r0d = 8'h00; d_r1d = 8'h00; d_rxr = 1'b0;
        d_tbre = 1'b1; d_tsre = 1'b1; d_dr = 1'b0; d_dout = 8'h00;
        @(negedge clk);
        chk("rst_status", d_st, 4'b0100);
        chk("rst_strobes", {d_wrn, d_rdn}, 2'b11);
        chk("rst_ready", {d_r0r, d_r1r}, 2'b00);
        chk("rst_rx", {d_rxv, d_rxd}, 0);
        chk("rst_din", d_din, 0);
        d_r0v = 1'b0; d_r1v = 1'b0;
        step();
        d_rst = 1'b1;
        lows = 0;
        repeat (8) begin
            @(negedge clk);
            lows += int'(!d_wrn || !d_rdn);
        end
        chk("idle_no_strobe", lows, 0);

        // single write: push in cycle N, wrn low in N+2..N+3
        step();
        d_r0v = 1'b1;
        d_r0d = 8'hA5;
        @(negedge clk);
        chk("tx_ready", d_r0r, 1);
        step();
        d_r0v = 1'b0;
        wexp = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("tx_wrn", d_wrn, wexp[3-k]);
            if (!d_wrn) chk("tx_din", d_din, 8'hA5);
            if (k == 3) chk("tx_wait_busy", d_st[0], 1);
            step();
            if (k == 2) d_tbre = 1'b0;
        end
        @(negedge clk);
        chk("tx_back_idle", d_st[0], 0);
        step();
        d_tbre = 1'b1;

        // guard expiry with tbre stuck high, then another byte
        push0(8'h5C);
        wwait(0, 1'b0, "g_start");
        chk("g_din", d_din, 8'h5C);
        wwait(0, 1'b1, "g_end");
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!d_st[0]) break;
            n++;
            @(negedge clk);
        end
        chk("guard_len", n, 15);
        push0(8'h6D);
        wwait(0, 1'b0, "g_next");
        chk("g_next_din", d_din, 8'h6D);

        // reset in the middle of a write strobe
        push0(8'h77);
        wwait(0, 1'b1, "rm_prev_end");
        wwait(0, 1'b0, "rm_start");
        #1 d_rst = 1'b0;
        #1;
        chk("rm_wrn", d_wrn, 1);
        chk("rm_status", d_st, 4'b0100);
        step();
        d_rst = 1'b1;
        lows = 0;
        repeat (10) begin
            @(negedge clk);
            lows += int'(!d_wrn);
        end
        chk("rm_discard", lows, 0);

        // round-robin into a blocked FIFO
        step();
        d_tbre = 1'b0;
        d_r0v = 1'b1; d_r0d = 8'h11;
        d_r1v = 1'b1; d_r1d = 8'h22;
        rexp = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b00};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rr_ready", {d_r0r, d_r1r}, rexp[k]);
            step();
        end
        chk("rr_full", d_st[3], 1);
        d_r0v = 1'b0; d_r1v = 1'b0; d_tbre = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wwait(0, 1'b0, "rr_wr");
            chk("rr_byte", d_din, (k % 2) ? 8'h22 : 8'h11);
            wwait(0, 1'b1, "rr_end");
        end

        // RX priority over pending TX, then back-pressure
        step();
        d_tbre = 1'b0;
        d_r0v = 1'b1; d_r0d = 8'h99;
        step();
        d_r0v = 1'b0; d_tbre = 1'b1;
        d_dr = 1'b1; d_dout = 8'h3C;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = !d_wrn || !d_rdn;
        end
        chk("rx_first", {d_wrn, d_rdn}, 2'b10);
        wwait(1, 1'b1, "rx_end");
        chk("rx_valid", d_rxv, 1);
        chk("rx_data", d_rxd, 8'h3C);
        step();
        d_dout = 8'h5A;
        lows = 0;
        wl = 0;
        repeat (40) begin
            @(negedge clk);
            lows += int'(!d_rdn);
            wl += int'(!d_wrn);
        end
        chk("rx_bp_no_rdn", lows, 0);
        chk("rx_bp_tx_runs", wl, 2);
        step();
        d_rxr = 1'b1;
        step();
        d_rxr = 1'b0;
        wwait(1, 1'b0, "rx2_start");
        wwait(1, 1'b1, "rx2_end");
        chk("rx2_data", d_rxd, 8'h5A);
        chk("rx2_valid", d_rxv, 1);
        d_dr = 1'b0;
        done++;
    end

    // ---------------- random instances vs. transaction model ----------------
    for (genvar g = 0; g < 3; g++) begin : g_rnd
        localparam int S = (g == 0) ? 2 : (g == 1) ? 1 : 7;
        logic       rst, r0v, r1v, r0r, r1r, rxv, rxr;
        logic       tbre, tsre, dr, wrn, rdn;
        logic [7:0] r0d, r1d, rxd, din, dout;
        logic [3:0] st;

        uart_access_ctrl #(.TX_DEPTH(4), .STROBE_CYCLES(S)) u_dut (
            .clk(clk), .rst(rst),
            .req0_valid(r0v), .req0_data(r0d), .req0_ready(r0r),
            .req1_valid(r1v), .req1_data(r1d), .req1_ready(r1r),
            .rx_valid(rxv), .rx_data(rxd), .rx_ready(rxr),
            .tbre(tbre), .tsre(tsre), .data_ready(dr),
            .uart_din(din), .uart_dout(dout),
            .wrn(wrn), .rdn(rdn), .status(st)
        );

        initial begin : run
            logic [7:0] q [$];
            logic [7:0] pd, rd_byte, wdin, rxd_m;
            logic       pend, last_m, rxv_m, pclr, wrn_p, rdn_p;
            logic       g0, g1, nf, acc0, acc1;
            int         wrun, rrun;
            rst = 1'b0; r0v = 1'b0; r1v = 1'b0; r0d = 8'h0; r1d = 8'h0;
            rxr = 1'b0; tbre = 1'b1; tsre = 1'b1; dr = 1'b0; dout = 8'h0;
            q = {}; pend = 1'b0; pd = 8'h0; last_m = 1'b1;
            rxv_m = 1'b0; rxd_m = 8'h0; pclr = 1'b0; rd_byte = 8'h0;
            wdin = 8'h0; wrn_p = 1'b1; rdn_p = 1'b1; wrun = 0; rrun = 0;
            repeat (2) @(posedge clk);
            #1 rst = 1'b1;
            for (int c = 0; c < 3000; c++) begin
                @(negedge clk);
                if (pend) q.push_back(pd);
                pend = 1'b0;
                if (pclr) rxv_m = 1'b0;
                pclr = 1'b0;
                if (!wrn_p && wrn) begin
                    chk("wr_width", wrun, S);
                    chk("wr_had_data", 32'(q.size() != 0), 1);
                    if (q.size() != 0) begin
                        chk("wr_byte", din, q[0]);
                        void'(q.pop_front());
                    end
                    wrun = 0;
                end
                if (!wrn && wrn_p) wdin = din;
                if (!wrn) begin
                    chk("din_stable", din, wdin);
                    wrun++;
                    if (wrun == S + 1) chk("wr_too_long", wrun, S);
                end
                if (!rdn_p && rdn) begin
                    chk("rd_width", rrun, S);
                    rxv_m = 1'b1;
                    rxd_m = rd_byte;
                    rrun = 0;
                end
                if (!rdn) begin
                    chk("rd_backpressure", rxv, 0);
                    rd_byte = dout;
                    rrun++;
                    if (rrun == S + 1) chk("rd_too_long", rrun, S);
                end
                chk("excl", 32'(!wrn && !rdn), 0);
                chk("rx_valid", rxv, rxv_m);
                chk("rx_data", rxd, rxd_m);
                chk("status", st[3:1],
                    {q.size() == 4, q.size() == 0, rxv_m});
                g0 = r0v && (!r1v || last_m);
                g1 = r1v && (!r0v || !last_m);
                nf = q.size() < 4;
                chk("ready0", r0r, g0 && nf);
                chk("ready1", r1r, g1 && nf);
                acc0 = g0 && nf;
                acc1 = g1 && nf;
                if (acc0) begin
                    pend = 1'b1; pd = r0d; last_m = 1'b0;
                end else if (acc1) begin
                    pend = 1'b1; pd = r1d; last_m = 1'b1;
                end
                pclr = rxv_m && rxr;
                wrn_p = wrn;
                rdn_p = rdn;
                @(posedge clk);
                #1;
                if (acc0 || !r0v) begin
                    r0v = ($urandom_range(0, 2) != 0);
                    r0d = 8'($urandom);
                end
                if (acc1 || !r1v) begin
                    r1v = ($urandom_range(0, 2) != 0);
                    r1d = 8'($urandom);
                end
                tbre = ($urandom_range(0, 9) != 0);
                tsre = ($urandom_range(0, 7) != 0);
                dr   = ($urandom_range(0, 3) == 0);
                dout = 8'($urandom);
                rxr  = ($urandom_range(0, 2) == 0);
            end
            done++;
        end
    end

    initial begin : finisher
        int t = 0;
        while (done < 4 && t < 20000) begin
            @(posedge clk);
            t++;
        end
        chk("all_done", done, 4);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
